// File: rtl/tex_cache_responder_pkg.sv
// Shared definitions for the texture cache: address field widths, fill FSM states,
// and the halfword selector used on the c1 read path.
package tex_cache_responder_pkg;

  localparam int TEX_ADR_W      = 19;
  localparam int TEX_LINE_ADR_W = 17;
  localparam int HW_SEL_W       = 2;
  localparam int LINE_W         = 64;
  localparam int BEAT_W         = 32;
  localparam int TEXEL_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEAT0,
    ST_BEAT1,
    ST_WRITE,
    ST_SETTLE
  } fill_state_e;

  // Halfword 0 sits in the lowest 16 bits of the line.
  function automatic logic [TEXEL_W-1:0] select_halfword(input logic [LINE_W-1:0] line,
                                                         input logic [HW_SEL_W-1:0] sel);
    return line[{sel, 4'b0000} +: TEXEL_W];
  endfunction

endpackage

// File: rtl/tex_cache_ram.sv
// Simple dual-port line store: synchronous read, 64-bit write, read-before-write
// when both ports address the same entry in one cycle.
module tex_cache_ram #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  // NOTE: the array has no reset; the valid bits kept beside it gate every use of its contents.
  logic [DATA_W-1:0] mem [2**IDX_W];

  // NOTE: non-blocking assignments make a same-entry read return the old line.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/tex_cache_responder.sv
// Direct-mapped texture cache: one-cycle lookup for the pixel pipeline and a
// single in-flight line fill from VRAM over a two-beat read port.
module tex_cache_responder
  import tex_cache_responder_pkg::*;
#(
  parameter int LINE_IDX_W = 8
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      requDataTex_c0,
  input  logic [TEX_ADR_W-1:0]      adrTexReq_c0,
  output logic                      TexHit_c1,
  output logic                      TexMiss_c1,
  output logic [TEXEL_W-1:0]        dataTex_c1,
  input  logic                      requTexCacheUpdate_c1,
  input  logic [TEX_LINE_ADR_W-1:0] adrTexCacheUpdate_c0,
  output logic                      updateTexCacheComplete,
  input  logic                      i_invalidate,
  output logic                      o_memReq,
  output logic [TEX_LINE_ADR_W-1:0] o_memAdr,
  input  logic                      i_memAck,
  input  logic                      i_memDataValid,
  input  logic [BEAT_W-1:0]         i_memData
);

  localparam int TAG_W = TEX_LINE_ADR_W - LINE_IDX_W;
  localparam int LINES = 1 << LINE_IDX_W;

  fill_state_e state, state_next;
  logic abort;
  logic [BEAT_W-1:0] beat0_q, beat1_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [LINES];

  logic [TEX_LINE_ADR_W-1:0] line_c0;
  logic [LINE_IDX_W-1:0]     idx_c0, wr_idx;
  logic [TAG_W-1:0]          tag_c0, wr_tag;
  logic                      wr_en;

  logic                      req_valid_c1, valid_rd_c1;
  logic [TAG_W-1:0]          req_tag_c1, tag_rd_c1;
  logic [HW_SEL_W-1:0]       hw_sel_c1;
  logic [LINE_W-1:0]         line_rd_c1;
  logic                      line_present_c1;

  assign line_c0 = adrTexReq_c0[TEX_ADR_W-1:HW_SEL_W];
  assign idx_c0  = line_c0[LINE_IDX_W-1:0];
  assign tag_c0  = line_c0[TEX_LINE_ADR_W-1:LINE_IDX_W];
  assign wr_idx  = o_memAdr[LINE_IDX_W-1:0];
  assign wr_tag  = o_memAdr[TEX_LINE_ADR_W-1:LINE_IDX_W];
  assign wr_en   = (state == ST_WRITE);

  tex_cache_ram #(.IDX_W(LINE_IDX_W), .DATA_W(LINE_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data ({beat1_q, beat0_q}),
    .rd_idx  (idx_c0),
    .rd_data (line_rd_c1)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      req_valid_c1 <= 1'b0;
      valid_rd_c1  <= 1'b0;
    end else begin
      req_valid_c1 <= requDataTex_c0;
      valid_rd_c1  <= valid_q[idx_c0];
    end
  end

  always_ff @(posedge clk) begin
    req_tag_c1 <= tag_c0;
    hw_sel_c1  <= adrTexReq_c0[HW_SEL_W-1:0];
    tag_rd_c1  <= tag_mem[idx_c0];
    if (wr_en) tag_mem[wr_idx] <= wr_tag;
  end

  // Invalidate beats a simultaneous line write.
  always_ff @(posedge clk) begin
    if (i_rst || i_invalidate) valid_q <= '0;
    else if (wr_en)            valid_q[wr_idx] <= !abort;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      o_memAdr <= '0;
      abort    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && requTexCacheUpdate_c1) begin
        o_memAdr <= adrTexCacheUpdate_c0;
        abort    <= 1'b0;
      end else if (i_invalidate && (state inside {ST_REQ, ST_BEAT0, ST_BEAT1})) begin
        abort <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_BEAT0 && i_memDataValid) beat0_q <= i_memData;
    if (state == ST_BEAT1 && i_memDataValid) beat1_q <= i_memData;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next             = state;
    o_memReq               = 1'b0;
    updateTexCacheComplete = 1'b0;
    case (state)
      ST_IDLE:   if (requTexCacheUpdate_c1) state_next = ST_REQ;
      ST_REQ: begin
        o_memReq = 1'b1;
        if (i_memAck) state_next = ST_BEAT0;
      end
      ST_BEAT0:  if (i_memDataValid) state_next = ST_BEAT1;
      ST_BEAT1:  if (i_memDataValid) state_next = ST_WRITE;
      ST_WRITE: begin
        updateTexCacheComplete = 1'b1;
        state_next             = ST_SETTLE;
      end
      // The miss visible now was looked up before the write landed; drop it.
      ST_SETTLE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign line_present_c1 = valid_rd_c1 && (tag_rd_c1 == req_tag_c1);
  assign TexHit_c1       = req_valid_c1 && line_present_c1;
  assign TexMiss_c1      = req_valid_c1 && !line_present_c1;
  assign dataTex_c1      = select_halfword(line_rd_c1, hw_sel_c1);

endmodule
